// File: rtl/core_v_mcu_pkg.sv
// Register-bus request/response types shared by core-v-mcu peripherals.
package core_v_mcu_pkg;

  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/reg_timer.sv
// reg_timer: 64-bit prescaled timer with compare/auto-reload, sticky
// pending flag and level interrupt, behind a zero-wait-state register bus.
//
// Handshake: a transfer happens in every cycle where req.valid is high;
// rsp.ready mirrors req.valid combinationally, and rdata/error belong to
// that same cycle. Writes commit on the rising edge closing the cycle.
module reg_timer #(
  parameter type reg_req_t = core_v_mcu_pkg::reg_req_t,
  parameter type reg_rsp_t = core_v_mcu_pkg::reg_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output logic     irq_o,
  output logic     tick_o
);

  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_PRESCALE = 12'h004;
  localparam logic [11:0] OFF_COUNT_LO = 12'h008;
  localparam logic [11:0] OFF_COUNT_HI = 12'h00C;
  localparam logic [11:0] OFF_CMP_LO   = 12'h010;
  localparam logic [11:0] OFF_CMP_HI   = 12'h014;
  localparam logic [11:0] OFF_STATUS   = 12'h018;

  // ctrl_q: {IRQ_EN, AUTO_RELOAD, EN}
  logic [2:0]  ctrl_q;
  logic [15:0] prescale_q;
  logic [15:0] pcnt_q;
  logic [63:0] count_q;
  logic [63:0] count_d;
  logic [63:0] cmp_q;
  logic        pending_q;
  logic [31:0] shadow_hi_q;

  logic [11:0] offset;
  logic        mapped;
  logic        acc_err;
  logic        wr_ok;
  logic        rd_ok;
  logic [31:0] rdata_sel;
  logic        match;
  logic        any_strb;
  logic        wr_ctrl, wr_prescale, wr_cnt_lo, wr_cnt_hi;
  logic        wr_cmp_lo, wr_cmp_hi, wr_status;
  logic        disable_wr;
  logic        unused_addr;

  // Only the low 12 address bits select a register; the demux owns the rest.
  assign unused_addr = ^reg_req_i.addr[63:12];

  assign offset   = reg_req_i.addr[11:0];
  assign any_strb = |reg_req_i.wstrb;

  // Merge written byte lanes of wd over old.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode and read-data selection.
  always_comb begin
    mapped    = 1'b1;
    rdata_sel = 32'd0;
    case (offset)
      OFF_CTRL:     rdata_sel = {29'd0, ctrl_q};
      OFF_PRESCALE: rdata_sel = {16'd0, prescale_q};
      OFF_COUNT_LO: rdata_sel = count_q[31:0];
      OFF_COUNT_HI: rdata_sel = shadow_hi_q;
      OFF_CMP_LO:   rdata_sel = cmp_q[31:0];
      OFF_CMP_HI:   rdata_sel = cmp_q[63:32];
      OFF_STATUS:   rdata_sel = {31'd0, pending_q};
      default:      mapped    = 1'b0;
    endcase
  end

  assign acc_err = reg_req_i.valid & (~mapped | (offset[1:0] != 2'b00));
  assign wr_ok   = reg_req_i.valid & ~acc_err & reg_req_i.write;
  assign rd_ok   = reg_req_i.valid & ~acc_err & ~reg_req_i.write;

  assign wr_ctrl     = wr_ok & (offset == OFF_CTRL);
  assign wr_prescale = wr_ok & (offset == OFF_PRESCALE);
  assign wr_cnt_lo   = wr_ok & (offset == OFF_COUNT_LO) & any_strb;
  assign wr_cnt_hi   = wr_ok & (offset == OFF_COUNT_HI) & any_strb;
  assign wr_cmp_lo   = wr_ok & (offset == OFF_CMP_LO);
  assign wr_cmp_hi   = wr_ok & (offset == OFF_CMP_HI);
  assign wr_status   = wr_ok & (offset == OFF_STATUS);

  // A CTRL write that clears EN while running resets the prescaler.
  assign disable_wr = wr_ctrl & reg_req_i.wstrb[0] & ~reg_req_i.wdata[0];

  assign tick_o = ctrl_q[0] & (pcnt_q == prescale_q);
  assign match  = (count_q == cmp_q);
  assign irq_o  = pending_q & ctrl_q[2];

  // Bus response: ready tracks valid, data/error only during a transfer.
  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    if (reg_req_i.valid) begin
      reg_rsp_o.error = acc_err;
      reg_rsp_o.rdata = acc_err ? 32'd0 : rdata_sel;
    end
  end

  // Next count: software writes override the tick; untouched lanes keep
  // their pre-tick value.
  always_comb begin
    count_d = count_q;
    if (tick_o) begin
      count_d = (match && ctrl_q[1]) ? 64'd0 : count_q + 64'd1;
    end
    if (wr_cnt_lo) begin
      count_d = {count_q[63:32],
                 merge_lanes(count_q[31:0], reg_req_i.wdata, reg_req_i.wstrb)};
    end
    if (wr_cnt_hi) begin
      count_d = {merge_lanes(count_q[63:32], reg_req_i.wdata, reg_req_i.wstrb),
                 count_q[31:0]};
    end
  end

  // Configuration registers: CTRL, PRESCALE, CMP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= 3'd0;
      prescale_q <= 16'd0;
      cmp_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      if (wr_ctrl && reg_req_i.wstrb[0]) ctrl_q <= reg_req_i.wdata[2:0];
      if (wr_prescale && reg_req_i.wstrb[0]) prescale_q[7:0]  <= reg_req_i.wdata[7:0];
      if (wr_prescale && reg_req_i.wstrb[1]) prescale_q[15:8] <= reg_req_i.wdata[15:8];
      if (wr_cmp_lo) cmp_q[31:0]  <= merge_lanes(cmp_q[31:0], reg_req_i.wdata, reg_req_i.wstrb);
      if (wr_cmp_hi) cmp_q[63:32] <= merge_lanes(cmp_q[63:32], reg_req_i.wdata, reg_req_i.wstrb);
    end
  end

  // Prescaler and main counter; both frozen while EN is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q  <= 16'd0;
      count_q <= 64'd0;
    end else begin
      if (ctrl_q[0]) begin
        if (disable_wr || tick_o) pcnt_q <= 16'd0;
        else                      pcnt_q <= pcnt_q + 16'd1;
      end
      count_q <= count_d;
    end
  end

  // Sticky pending flag (W1C, set wins) and COUNT_HI read shadow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q   <= 1'b0;
      shadow_hi_q <= 32'd0;
    end else begin
      if (tick_o && match) begin
        pending_q <= 1'b1;
      end else if (wr_status && reg_req_i.wstrb[0] && reg_req_i.wdata[0]) begin
        pending_q <= 1'b0;
      end
      if (rd_ok && (offset == OFF_COUNT_LO)) shadow_hi_q <= count_q[63:32];
    end
  end

endmodule

// File: tb/tb_reg_timer.sv
// Self-checking bench for reg_timer.
module tb_reg_timer;

  core_v_mcu_pkg::reg_req_t req;
  core_v_mcu_pkg::reg_rsp_t rsp;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic irq_o;
  logic tick_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] rd;
  logic        er;
  logic        rdy;

  // Clock / reset
  always #5 clk_i = ~clk_i;

  reg_timer dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .reg_req_i (req),
    .reg_rsp_o (rsp),
    .irq_o     (irq_o),
    .tick_o    (tick_o)
  );

  // Driver: one bus cycle, driven on the falling edge, sampled 1ns later,
  // committed on the next rising edge.
  task automatic bus(input logic [11:0] off, input logic wr, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rdv,
                     output logic erv, output logic rdyv);
    @(negedge clk_i);
    req.addr  = {32'($urandom), 20'h0, off};
    req.write = wr;
    req.wdata = wd;
    req.wstrb = st;
    req.valid = 1'b1;
    #1;
    rdv  = rsp.rdata;
    erv  = rsp.error;
    rdyv = rsp.ready;
    @(posedge clk_i);
    #1;
    req.valid = 1'b0;
    req.write = 1'b0;
    req.wstrb = 4'h0;
    req.wdata = $urandom;
  endtask

  task automatic wr32(input logic [11:0] off, input logic [31:0] d);
    bus(off, 1'b1, d, 4'hF, rd, er, rdy);
  endtask

  task automatic rd32(input logic [11:0] off);
    bus(off, 1'b0, 32'd0, 4'h0, rd, er, rdy);
  endtask

  task automatic test_reset();
    logic [11:0] offs [7];
    logic [31:0] exps [7];
    offs = '{12'h00, 12'h04, 12'h08, 12'h0C, 12'h10, 12'h14, 12'h18};
    exps = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq_o); end
    n_checks++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    n_checks++; if ({rsp.rdata, rsp.error, rsp.ready} !== 34'd0) begin
      n_fail++; $display("FAIL idle_rsp got %h/%b/%b want 0/0/0", rsp.rdata, rsp.error, rsp.ready);
    end
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(exps[i]);
      rd32(offs[i]);
      exp_v = exp_q.pop_front();
      n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL reset_read[%h] got %h want %h", offs[i], rd, exp_v); end
      n_checks++; if ({er, rdy} !== 2'b01) begin n_fail++; $display("FAIL reset_rsp[%h] err/rdy got %b%b want 01", offs[i], er, rdy); end
    end
  endtask

  task automatic test_prescale();
    wr32(12'h04, 32'd3);
    wr32(12'h10, 32'd5);
    wr32(12'h14, 32'd0);
    wr32(12'h00, 32'h5);
    for (int k = 0; k < 26; k++) begin
      @(negedge clk_i);
      #1;
      n_checks++; if (tick_o !== ((k % 4) == 3)) begin n_fail++; $display("FAIL prescale_tick k=%0d got %b want %b", k, tick_o, ((k % 4) == 3)); end
      n_checks++; if (irq_o !== (k >= 24)) begin n_fail++; $display("FAIL prescale_irq k=%0d got %b want %b", k, irq_o, (k >= 24)); end
    end
    wr32(12'h00, 32'h0);
    exp_q.push_back(32'd6); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    rd32(12'h08); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL prescale_count_lo got %h want %h", rd, exp_v); end
    rd32(12'h0C); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL prescale_count_hi got %h want %h", rd, exp_v); end
    rd32(12'h18); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL prescale_status got %h want %h", rd, exp_v); end
    wr32(12'h18, 32'h1);
    wr32(12'h08, 32'h0);
  endtask

  task automatic test_en_clear();
    wr32(12'h00, 32'h1);
    repeat (2) @(negedge clk_i);
    wr32(12'h00, 32'h0);
    wr32(12'h00, 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      #1;
      n_checks++; if (tick_o !== (k == 3)) begin n_fail++; $display("FAIL en_clear_tick k=%0d got %b want %b", k, tick_o, (k == 3)); end
    end
    wr32(12'h00, 32'h0);
    exp_q.push_back(32'd1);
    rd32(12'h08); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL en_clear_count got %h want %h", rd, exp_v); end
    wr32(12'h08, 32'h0);
  endtask

  task automatic test_auto_reload();
    wr32(12'h04, 32'd0);
    wr32(12'h10, 32'd2);
    wr32(12'h00, 32'h3);
    for (int k = 0; k < 9; k++) exp_q.push_back(32'(k % 3));
    for (int k = 0; k < 9; k++) begin
      rd32(12'h08);
      exp_v = exp_q.pop_front();
      n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL reload_count k=%0d got %h want %h", k, rd, exp_v); end
      n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reload_irq k=%0d got %b want 0", k, irq_o); end
    end
    exp_q.push_back(32'd1);
    rd32(12'h18); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL reload_status got %h want %h", rd, exp_v); end
    wr32(12'h00, 32'h0);
    wr32(12'h08, 32'h0);
    wr32(12'h18, 32'h1);
  endtask

  task automatic test_wrap();
    wr32(12'h10, 32'd5);
    wr32(12'h08, 32'hFFFF_FFFF);
    wr32(12'h0C, 32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'hFFFF_FFFF);
    rd32(12'h08); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL wrap_pre_lo got %h want %h", rd, exp_v); end
    rd32(12'h0C); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL wrap_pre_hi got %h want %h", rd, exp_v); end
    wr32(12'h00, 32'h1);
    wr32(12'h00, 32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    rd32(12'h08); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL wrap_lo got %h want %h", rd, exp_v); end
    rd32(12'h0C); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL wrap_hi got %h want %h", rd, exp_v); end
    rd32(12'h18); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL wrap_status got %h want %h", rd, exp_v); end
  endtask

  task automatic test_count_write();
    wr32(12'h10, 32'd0);
    wr32(12'h00, 32'h1);
    wr32(12'h08, 32'h100);
    wr32(12'h00, 32'h0);
    exp_q.push_back(32'h101); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    rd32(12'h08); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL cwrite_lo got %h want %h", rd, exp_v); end
    rd32(12'h0C); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL cwrite_hi got %h want %h", rd, exp_v); end
    rd32(12'h18); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL cwrite_status got %h want %h", rd, exp_v); end
    bus(12'h0C, 1'b1, 32'h1234_AB56, 4'b0010, rd, er, rdy);
    exp_q.push_back(32'h101); exp_q.push_back(32'h0000_AB00);
    rd32(12'h08); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL cwrite_lane_lo got %h want %h", rd, exp_v); end
    rd32(12'h0C); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL cwrite_lane_hi got %h want %h", rd, exp_v); end
    wr32(12'h18, 32'h1);
    wr32(12'h08, 32'h0);
    wr32(12'h0C, 32'h0);
  endtask

  task automatic test_w1c_race();
    wr32(12'h10, 32'd2);
    wr32(12'h00, 32'h7);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    rd32(12'h08); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL race_count0 got %h want %h", rd, exp_v); end
    rd32(12'h08); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL race_count1 got %h want %h", rd, exp_v); end
    wr32(12'h18, 32'h1);
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL race_set_wins irq got %b want 1", irq_o); end
    wr32(12'h18, 32'h1);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL race_clear irq got %b want 0", irq_o); end
    wr32(12'h00, 32'h0);
    exp_q.push_back(32'd0);
    rd32(12'h18); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL race_status got %h want %h", rd, exp_v); end
    wr32(12'h08, 32'h0);
  endtask

  task automatic test_errors();
    rd32(12'h1C);
    n_checks++; if ({rd, er} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL err_rd1c got %h/%b want 0/1", rd, er); end
    bus(12'h1C, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, rdy);
    n_checks++; if ({rd, er, rdy} !== {32'd0, 2'b11}) begin n_fail++; $display("FAIL err_wr1c got %h/%b/%b want 0/1/1", rd, er, rdy); end
    bus(12'h06, 1'b1, 32'h0000_1234, 4'hF, rd, er, rdy);
    n_checks++; if ({rd, er} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL err_wr06 got %h/%b want 0/1", rd, er); end
    rd32(12'h06);
    n_checks++; if ({rd, er} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL err_rd06 got %h/%b want 0/1", rd, er); end
    exp_q.push_back(32'd0);
    rd32(12'h04); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL err_prescale_kept got %h want %h", rd, exp_v); end
    wr32(12'h10, 32'hFFFF_FFFF);
    bus(12'h10, 1'b1, 32'hAABB_CCDD, 4'b0001, rd, er, rdy);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL lane_wr_err got %b want 0", er); end
    bus(12'h10, 1'b1, 32'h0, 4'b0000, rd, er, rdy);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL nostrb_err got %b want 0", er); end
    exp_q.push_back(32'hFFFF_FFDD);
    rd32(12'h10); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL lane_cmp_lo got %h want %h", rd, exp_v); end
    wr32(12'h00, 32'hFFFF_FFF8);
    wr32(12'h04, 32'hABCD_1234);
    exp_q.push_back(32'd0); exp_q.push_back(32'h0000_1234);
    rd32(12'h00); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL ctrl_upper got %h want %h", rd, exp_v); end
    rd32(12'h04); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL prescale_upper got %h want %h", rd, exp_v); end
    wr32(12'h04, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [11:0] offs [7];
    logic [31:0] exps [7];
    offs = '{12'h0C, 12'h00, 12'h04, 12'h08, 12'h10, 12'h14, 12'h18};
    exps = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    wr32(12'h10, 32'h1233);
    wr32(12'h14, 32'h0);
    wr32(12'h08, 32'h1233);
    wr32(12'h00, 32'h5);
    wr32(12'h00, 32'h4);
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL mid_irq_before got %b want 1", irq_o); end
    exp_q.push_back(32'h1234);
    rd32(12'h08); exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL mid_count_before got %h want %h", rd, exp_v); end
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL mid_irq_async got %b want 0", irq_o); end
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(exps[i]);
      rd32(offs[i]);
      exp_v = exp_q.pop_front();
      n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL mid_read[%h] got %h want %h", offs[i], rd, exp_v); end
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      #1;
      n_checks++; if ({tick_o, irq_o} !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle k=%0d tick/irq got %b%b want 00", k, tick_o, irq_o); end
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req    = '0;
    rst_ni = 1'b0;
    test_reset();
    test_prescale();
    test_en_clear();
    test_auto_reload();
    test_wrap();
    test_count_write();
    test_w1c_race();
    test_errors();
    test_reset_mid();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_timer.md
REG_TIMER -- requirements
Module: reg_timer

Interface
REQ-001 SHALL have parameter reg_req_t, default core_v_mcu_pkg::reg_req_t, register-bus request type (addr 64b, write, wdata 32b, wstrb 4b, valid).
REQ-002 SHALL have parameter reg_rsp_t, default core_v_mcu_pkg::reg_rsp_t, register-bus response type (rdata 32b, error, ready).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port reg_req_i  input  reg_req_t  register-bus request from the peripheral demux.
REQ-006 SHALL have port reg_rsp_o  output  reg_rsp_t  register-bus response.
REQ-007 SHALL have port irq_o  output  1  level timer interrupt to fast interrupt controller.
REQ-008 SHALL have port tick_o  output  1  one-cycle pulse per counter increment.

Function
REQ-009 SHALL decode offset = addr[11:0]; map: 0x00 CTRL, 0x04 PRESCALE, 0x08 COUNT_LO, 0x0C COUNT_HI, 0x10 CMP_LO, 0x14 CMP_HI, 0x18 STATUS.
REQ-010 SHALL set ready = valid combinationally (zero-wait-state); rdata/error valid in the same cycle.
REQ-011 SHALL assert error, with no state change and rdata = 0, for unmapped offset or addr[1:0] != 0.
REQ-012 SHALL drive rdata = 0 and error = 0 when valid = 0.
REQ-013 SHALL apply writes per byte lane via wstrb; wstrb = 0 writes nothing and returns no error.
REQ-014 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; bits 31:3 read 0, writes ignored.
REQ-015 PRESCALE: bits 15:0 R/W; bits 31:16 read 0.
REQ-016 Prescaler: 16-bit pcnt; while EN=1, tick when pcnt == PRESCALE, then pcnt <= 0, else pcnt <= pcnt+1; PRESCALE = 0 -> tick every cycle.
REQ-017 EN=0 SHALL freeze count and pcnt; writing EN 1->0 SHALL clear pcnt on the same edge.
REQ-018 tick_o SHALL be high exactly in cycles where a tick occurs (combinational from pcnt/PRESCALE/EN).
REQ-019 On tick: match = (count == CMP); if match and AUTO_RELOAD, count <= 0; else count <= count+1 modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF -> 0).
REQ-020 On tick with match, STATUS.PENDING (bit0) SHALL set on the same edge.
REQ-021 STATUS bit0 is write-1-to-clear; simultaneous set and clear -> set wins.
REQ-022 irq_o = PENDING & IRQ_EN, registered-state-derived, no extra latency.
REQ-023 SW write to COUNT_LO/COUNT_HI in a tick cycle SHALL win: written lanes take wdata, unwritten lanes keep pre-tick value, no increment that cycle; match still evaluated on pre-write count.
REQ-024 Reading COUNT_LO SHALL return count[31:0] and load shadow_hi <= count[63:32]; reading COUNT_HI SHALL return shadow_hi.
REQ-025 Writing CMP_LO/CMP_HI SHALL take effect from the next cycle; no retroactive match.
REQ-026 PRESCALE write while running SHALL take effect next cycle; if pcnt > new PRESCALE, pcnt counts up to 0xFFFF and wraps to 0 without tick at wrap.

Reset
REQ-027 On rst_ni low, asynchronously: CTRL = 0, PRESCALE = 0, pcnt = 0, count = 0, CMP = 0xFFFF_FFFF_FFFF_FFFF, PENDING = 0, shadow_hi = 0.
REQ-028 During reset irq_o = 0, tick_o = 0; reg_rsp_o follows REQ-010/012 from state reset values.
REQ-029 Reset mid-count SHALL discard all progress; first tick after release requires EN write.

Verification
REQ-030 PRESCALE=3, CMP=5, CTRL=0x5 -> tick_o every 4th cycle; PENDING and irq_o rise on the 6th tick; count continues to 6.
REQ-031 CTRL=0x3, PRESCALE=0, CMP=2 -> count sequence 0,1,2,0,1,2; PENDING set at each count=2 tick; irq_o stays 0 (IRQ_EN=0).
REQ-032 COUNT_LO=0xFFFF_FFFF, COUNT_HI=0xFFFF_FFFF, EN=1, PRESCALE=0 -> next cycle count = 0; read COUNT_LO=0 then COUNT_HI=0.
REQ-033 STATUS write 0x1 in same cycle as a new match -> PENDING remains 1; write 0x1 next cycle -> PENDING 0, irq_o 0.
REQ-034 Access offset 0x1C and offset 0x06 -> error=1, rdata=0, no register change; wstrb=4'b0001 to CMP_LO with 0xAABBCCDD -> CMP_LO = 0xFFFFFFDD.
REQ-035 Assert rst_ni low while count = 0x1234 and PENDING=1 -> immediately irq_o=0, all reads return reset values.
